// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer: drives one PE through a dot product and accumulates its products (optional zero-pair skipping via PE_ZERO_SKIP_EN).
module pe_dot_sequencer #(
  parameter int VEC_LEN_W = 8,
  parameter int PE_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [VEC_LEN_W-1:0]   i_len,
  output logic                   o_busy,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [3:0]             i_weight,
  input  logic [7:0]             i_activation,
  output logic [3:0]             o_pe_weight,
  output logic [7:0]             o_pe_activation,
  input  logic [14:0]            i_pe_calculated,
  output logic                   o_result_valid,
  input  logic                   i_result_ready,
  output logic [15+VEC_LEN_W-1:0] o_result,
  output logic [VEC_LEN_W-1:0]   o_skip_count
);
  localparam int ACC_W = 15 + VEC_LEN_W;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [VEC_LEN_W-1:0] r_rem;
  logic [PE_LAT-1:0] r_tags;
  logic [ACC_W-1:0] r_acc;
  logic [3:0] r_pe_w;
  logic [7:0] r_pe_a;
  logic w_hs, w_zero, w_issue, w_last, w_start;
  assign w_hs    = i_in_valid && r_state == FEED;
  assign w_start = i_start && r_state == IDLE;
  assign w_issue = w_hs && !w_zero;
  assign w_last  = r_rem == VEC_LEN_W'(1);
  assign o_busy          = r_state != IDLE;
  assign o_in_ready      = r_state == FEED;
  assign o_result_valid  = r_state == DONE;
  assign o_pe_weight     = r_pe_w;
  assign o_pe_activation = r_pe_a;
  assign o_result        = r_acc;
`ifdef PE_ZERO_SKIP_EN
  logic [VEC_LEN_W-1:0] r_skip;
  assign w_zero       = i_weight == 4'd0 || i_activation == 8'd0;
  assign o_skip_count = r_skip;
  always_ff @(posedge clk) begin
    if (rst) r_skip <= '0;
    else if (w_start) r_skip <= '0;
    else if (w_hs && w_zero) r_skip <= r_skip + VEC_LEN_W'(1);
  end
`else
  assign w_zero       = 1'b0;
  assign o_skip_count = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // DRAIN waits one edge past the final accumulation so the tags are provably empty
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? (i_len == '0 ? DONE : FEED) : IDLE;
      FEED:    w_next = w_hs && w_last ? DRAIN : FEED;
      DRAIN:   w_next = r_tags == '0 ? DONE : DRAIN;
      DONE:    w_next = i_result_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_tags <= '0;
      r_acc  <= '0;
      r_pe_w <= '0;
      r_pe_a <= '0;
    end else begin
      r_pe_w <= w_issue ? i_weight : 4'd0;
      r_pe_a <= w_issue ? i_activation : 8'd0;
      r_tags <= (r_tags << 1) | PE_LAT'(w_issue);
      if (w_start) begin
        r_rem <= i_len;
        r_acc <= '0;
      end else begin
        if (w_hs) r_rem <= r_rem - VEC_LEN_W'(1);
        if (r_tags[PE_LAT-1]) r_acc <= r_acc + ACC_W'(i_pe_calculated);
      end
    end
  end
endmodule

// File: tb/tb_pe_dot_sequencer.sv
// tb_pe_dot_sequencer: table-driven scoreboard bench with a behavioural PE of latency 2.
module tb_pe_dot_sequencer;
  localparam int LAT = 2;
`ifdef PE_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic i_start = 1'b0, i_in_valid = 1'b0, i_result_ready = 1'b0;
  logic [7:0] i_len = '0, i_activation = '0;
  logic [3:0] i_weight = '0;
  logic o_busy, o_in_ready, o_result_valid;
  logic [3:0] o_pe_weight;
  logic [7:0] o_pe_activation, o_skip_count;
  logic [14:0] i_pe_calculated, r_p;
  logic [22:0] o_result;
  always #5 clk = ~clk;
  // one register after the registered operands gives the two-edge PE latency
  always_ff @(posedge clk) r_p <= 15'(o_pe_weight) * 15'(o_pe_activation);
  assign i_pe_calculated = r_p;
  pe_dot_sequencer #(.VEC_LEN_W(8), .PE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .o_busy(o_busy),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_weight(i_weight),
    .i_activation(i_activation), .o_pe_weight(o_pe_weight),
    .o_pe_activation(o_pe_activation), .i_pe_calculated(i_pe_calculated),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_result(o_result), .o_skip_count(o_skip_count)
  );
  typedef struct {
    logic [7:0] len;
    logic [0:7][3:0] w;
    logic [0:7][7:0] a;
    bit gap;
    bit bp;
    logic [22:0] res;
    logic [7:0] skip;
  } vec_t;
  typedef struct {
    logic [22:0] res;
    logic [7:0] skip;
  } exp_t;
  vec_t vecs[7];
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic run_vec(input int idx);
    vec_t v = vecs[idx];
    exp_t e;
    int cnt;
    bit z;
    logic [22:0] hold;
    i_len = v.len;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    sb.push_back('{v.res, SKIP_EN ? v.skip : 8'd0});
    if (v.len == 8'd0) begin
      check("zero_len_valid", 32'(o_result_valid), 32'd1);
      check("zero_len_ready", 32'(o_in_ready), 32'd0);
    end else begin
      for (int i = 0; i < int'(v.len); i++) begin
        if (v.gap && i > 0) begin
          i_in_valid = 1'b0;
          @(posedge clk); #1;
          check("gap_pe_w", 32'(o_pe_weight), 32'd0);
          check("gap_pe_a", 32'(o_pe_activation), 32'd0);
        end
        i_in_valid = 1'b1;
        i_weight = v.w[i];
        i_activation = v.a[i];
        check("in_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
        z = SKIP_EN && (v.w[i] == 4'd0 || v.a[i] == 8'd0);
        check("pe_w", 32'(o_pe_weight), z ? 32'd0 : 32'(v.w[i]));
        check("pe_a", 32'(o_pe_activation), z ? 32'd0 : 32'(v.a[i]));
      end
      i_in_valid = 1'b0;
      i_weight = '0;
      i_activation = '0;
      cnt = 0;
      while (!o_result_valid && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("latency", 32'(cnt), 32'(LAT + 1));
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      check("result", 32'(o_result), 32'(e.res));
      check("skip_count", 32'(o_skip_count), 32'(e.skip));
    end
    if (v.bp) begin
      hold = o_result;
      for (int i = 0; i < 10; i++) begin
        i_start = (i == 3 || i == 7);
        i_len = 8'd5;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("bp_valid", 32'(o_result_valid), 32'd1);
        check("bp_result", 32'(o_result), 32'(hold));
        check("bp_ready", 32'(o_in_ready), 32'd0);
      end
    end
    i_result_ready = 1'b1;
    @(posedge clk); #1;
    i_result_ready = 1'b0;
    check("release_busy", 32'(o_busy), 32'd0);
    check("release_valid", 32'(o_result_valid), 32'd0);
  endtask
  initial begin
    vecs[0] = '{8'd4, '{4'd1, 4'd2, 4'd3, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0},
                '{8'd10, 8'd20, 8'd30, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b0, 23'd3965, 8'd0};
    vecs[1] = '{8'd0, '0, '0, 1'b0, 1'b0, 23'd0, 8'd0};
    vecs[2] = vecs[0];
    vecs[2].gap = 1'b1;
    vecs[3] = vecs[0];
    vecs[3].bp = 1'b1;
    vecs[4] = '{8'd3, '{4'd0, 4'd5, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
                '{8'd9, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b0, 23'd14, 8'd2};
    vecs[5] = '{8'd8, '{8{4'd15}}, '{8{8'd255}}, 1'b0, 1'b0, 23'd30600, 8'd0};
    vecs[6] = '{8'd1, '{4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
                '{8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b0, 23'd12, 8'd0};
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready", 32'(o_in_ready), 32'd0);
    check("rst_valid", 32'(o_result_valid), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) run_vec(i);
    i_len = 8'd4;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_in_valid = 1'b1;
    i_weight = 4'd9;
    i_activation = 8'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_ready", 32'(o_in_ready), 32'd0);
    check("midrst_valid", 32'(o_result_valid), 32'd0);
    check("midrst_result", 32'(o_result), 32'd0);
    check("midrst_pe_w", 32'(o_pe_weight), 32'd0);
    check("midrst_pe_a", 32'(o_pe_activation), 32'd0);
    check("midrst_skip", 32'(o_skip_count), 32'd0);
    rst = 1'b0;
    i_in_valid = 1'b0;
    i_weight = '0;
    i_activation = '0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_result", 32'(o_result_valid), 32'd0);
    run_vec(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
